axi_wr_split_ctrl: RTL
======================

# axi_wr_split_ctrl

Sequencing controller for the AXI4-to-AXI3 write path. Accepts one AXI4 write burst at a time, loads the virtual master (`Load_The_Original_Signals`), and issues `Burst_Out` for each AXI3 sub-burst address. Passes the write data through while regenerating `WLAST` on 16-beat boundaries, then merges the per-sub-burst B responses into one AXI4 response. Sits beside the virtual master, between the selected AXI4 master and the AXI3 slave port.

## Interface
Parameters:
- `Data_width`, 32: W data width; strobe width is `Data_width/8`.
- `AXI3_Aw_len`, 4: sub-burst length field width; maximum sub-burst is 16 beats.

Ports:
- `ACLK`, in, 1: clock. One clock; all state on its rising edge.
- `ARESETN`, in, 1: reset, asynchronous, active-low.
- `S_AXI_awvalid`, in, 1; `S_AXI_awready`, out, 1: AXI4 AW handshake (only valid/ready are used here).
- `Token`, in, 1: arbiter grant; the same signal that feeds the virtual master.
- `Load_The_Original_Signals`, out, 1: one-cycle load pulse to the virtual master.
- `Burst_Out`, out, 1: sub-burst address accepted downstream.
- `Last_Trans`, in, 1; `Sub_Len`, in, `AXI3_Aw_len`: virtual master status and current `awlen`.
- `M_AXI_awready`, in, 1: AXI3 slave AW ready.
- `S_AXI_wdata`, `S_AXI_wstrb`, `S_AXI_wlast`, `S_AXI_wvalid` in; `S_AXI_wready` out: AXI4 W channel.
- `M_AXI_wdata`, `M_AXI_wstrb`, `M_AXI_wlast`, `M_AXI_wvalid` out; `M_AXI_wready` in: AXI3 W channel.
- `M_AXI_bresp`, in, 2; `M_AXI_bvalid`, in, 1; `M_AXI_bready`, out, 1: AXI3 B channel.
- `S_AXI_bresp`, out, 2; `S_AXI_bvalid`, out, 1; `S_AXI_bready`, in, 1: AXI4 B channel.
- `Busy`, out, 1: state not IDLE.
- `Protocol_Err`, out, 1: sticky upstream WLAST error (see Configuration).

## Operation
- FSM states: IDLE, LOAD, ADDR, DATA, RESP, SRESP.
- **IDLE → LOAD:** when `S_AXI_awvalid && Token`. In that cycle, `S_AXI_awready=1` and `Load_The_Original_Signals=1`, both combinational.
- **LOAD → ADDR:** unconditional, one cycle. This lets the virtual master registers settle.
- **ADDR:**
  - `Burst_Out = M_AXI_awready && Token`, combinational.
  - On `Burst_Out`: capture `Sub_Len` into `len_q` and `Last_Trans` into `last_q`, clear `beat_cnt`, go to DATA.
  - If `Token` is low, wait with no side effects.
- **DATA:**
  - `M_AXI_wvalid=S_AXI_wvalid`, `S_AXI_wready=M_AXI_wready`; data and strobe pass through combinationally.
  - `M_AXI_wlast = (beat_cnt==len_q)`.
  - `beat_cnt` (`AXI3_Aw_len` bits) increments on each W handshake.
  - The handshake with `M_AXI_wlast` high moves to RESP.
- **RESP:**
  - `M_AXI_bready=1`.
  - On `M_AXI_bvalid`: `resp_acc <= max(resp_acc, M_AXI_bresp)`, a numeric max where DECERR outranks SLVERR, which outranks EXOKAY, which outranks OKAY.
  - Then go to SRESP if `last_q`, else back to ADDR.
- **SRESP:**
  - `S_AXI_bvalid=1`, `S_AXI_bresp=resp_acc`.
  - On `S_AXI_bready`, go to IDLE.
- `resp_acc` clears on the LOAD pulse.
- Outside DATA: `M_AXI_wvalid=0`, `S_AXI_wready=0`, `M_AXI_wlast=0`.

## Timing
- **Reset values:**
  - State IDLE; `beat_cnt`, `len_q`, `last_q`, `resp_acc` all 0.
  - Every handshake output, `Busy`, `Load_The_Original_Signals`, `Burst_Out` and `Protocol_Err` are 0.
  - `M_AXI_wdata`/`wstrb` follow their inputs.
- **Latencies:**
  - AW accept to first `Burst_Out`: minimum 2 cycles (LOAD, then ADDR with `M_AXI_awready` high).
  - W path: zero latency, no buffering.
- `Burst_Out` and `Load_The_Original_Signals` are never high in the same cycle.
- `Burst_Out` fires at most once per sub-burst.
- **Token:** a drop during DATA, RESP or SRESP is ignored; the transaction completes. A drop in ADDR stalls.
- **Reset mid-burst:** returns to IDLE immediately. Partially sent sub-bursts are abandoned, with no response generated.
- **Length boundaries:** `Sub_Len=0` gives a single beat with `wlast` on beat 0. `Sub_Len=15` gives `wlast` on beat 15, and `beat_cnt` must not wrap before the compare.
- **B channel ordering:** `M_AXI_bvalid` asserted before RESP is held by the slave; this block never accepts B outside RESP.

## Configuration
- Macro: `AXI_WR_SPLIT_WLAST_CHECK_EN`.
- **Defined:**
  - In DATA, a W handshake where `S_AXI_wlast != (last_q && M_AXI_wlast)` sets `Protocol_Err` on the next edge.
  - `Protocol_Err` stays high until `ARESETN` is asserted.
  - The data flow is unaffected.
- **Undefined:** `S_AXI_wlast` is ignored and `Protocol_Err` is constant 0.

## Test plan
- **awlen=0x23 (36 beats), slave always ready, all OKAY:** 3 `Burst_Out` pulses with `Sub_Len` 15, 15, 3. `M_AXI_wlast` on beats 15, 31 and 35. One `S_AXI_bvalid` with resp 00.
- **awlen=0x00:** LOAD, then one `Burst_Out`. Single beat with `M_AXI_wlast=1` and `Last_Trans=1`. One upstream B.
- **awlen=0x1F, second sub-burst B=SLVERR (10):** `S_AXI_bresp=10`. Exactly 2 `M_AXI_bready` handshakes.
- **Backpressure, awlen=0x0F:** `M_AXI_wready` toggles every cycle and `M_AXI_awready` is low for 5 cycles. `Burst_Out` is delayed 5 cycles, 16 beats are delivered with none lost, and `wlast` appears only on the 16th.
- **Token dropped in ADDR for 3 cycles:** no `Burst_Out` while `Token` is low, resumes afterwards.
- **Reset and WLAST check:** `ARESETN` pulsed low mid-DATA gives `Busy=0` and all valids 0 within the same cycle. With `AXI_WR_SPLIT_WLAST_CHECK_EN` defined, an upstream `S_AXI_wlast` on beat 15 of awlen=0x1F sets `Protocol_Err=1`.

Source files
------------

// File: rtl/axi_wr_split_ctrl.sv
// axi_wr_split_ctrl
// Sequencing controller for the AXI4-to-AXI3 write path. It takes one AXI4
// write burst at a time and pulses the virtual master load. It then issues
// one Burst_Out per AXI3 sub-burst address and passes write data straight
// through, regenerating WLAST every sub-burst. The per-sub-burst B responses
// are merged into a single AXI4 response, keeping the worst one.
//
// Optional feature macro: AXI_WR_SPLIT_WLAST_CHECK_EN
//   When defined, every W handshake compares the upstream S_AXI_wlast with the
//   position of the final beat of the whole AXI4 burst. Any disagreement sets
//   the sticky Protocol_Err flag, which clears only on reset.
//   When undefined, S_AXI_wlast is ignored and Protocol_Err is tied low.

module axi_wr_split_ctrl #(
    parameter int Data_width  = 32,
    parameter int AXI3_Aw_len = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,

    // AXI4 address handshake from the selected master
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,

    // Arbiter grant and virtual master interaction
    input  logic                    Token,
    output logic                    Load_The_Original_Signals,
    output logic                    Burst_Out,
    input  logic                    Last_Trans,
    input  logic [AXI3_Aw_len-1:0]  Sub_Len,

    // AXI3 slave address ready
    input  logic                    M_AXI_awready,

    // AXI4 write data channel
    input  logic [Data_width-1:0]   S_AXI_wdata,
    input  logic [Data_width/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,

    // AXI3 write data channel
    output logic [Data_width-1:0]   M_AXI_wdata,
    output logic [Data_width/8-1:0] M_AXI_wstrb,
    output logic                    M_AXI_wlast,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,

    // AXI3 write response channel
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,

    // AXI4 write response channel
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,

    // Status
    output logic                    Busy,
    output logic                    Protocol_Err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        RESP  = 3'd4,
        SRESP = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [AXI3_Aw_len-1:0] beat_cnt;
    logic [AXI3_Aw_len-1:0] len_q;
    logic                   last_q;
    logic [1:0]             resp_acc;

    logic                   w_hs;
    logic                   beat_is_last;

    // AXI response codes are ordered so that the numerically larger code is
    // the more severe one (DECERR > SLVERR > EXOKAY > OKAY).
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // The final beat of the current sub-burst is reached when the beat counter
    // equals the captured awlen. The compare happens before the increment, so
    // a 16-beat sub-burst (len 15) never sees the counter wrap first.
    assign beat_is_last = (beat_cnt == len_q);

    // A W beat moves only while in DATA and both sides agree.
    assign w_hs = (state == DATA) && S_AXI_wvalid && M_AXI_wready;

    // Write data and strobes are a pure pass-through with no buffering.
    assign M_AXI_wdata = S_AXI_wdata;
    assign M_AXI_wstrb = S_AXI_wstrb;

    assign Busy = (state != IDLE);

    // State register; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and all handshake outputs, derived from the current state.
    always_comb begin
        state_nxt                 = state;
        S_AXI_awready             = 1'b0;
        Load_The_Original_Signals = 1'b0;
        Burst_Out                 = 1'b0;
        M_AXI_wvalid              = 1'b0;
        S_AXI_wready              = 1'b0;
        M_AXI_wlast               = 1'b0;
        M_AXI_bready              = 1'b0;
        S_AXI_bvalid              = 1'b0;
        S_AXI_bresp               = 2'b00;

        case (state)
            IDLE: begin
                // Gating with ARESETN keeps the AW accept and load pulse low
                // while reset is held, even if a request is waiting.
                if (ARESETN && S_AXI_awvalid && Token) begin
                    S_AXI_awready             = 1'b1;
                    Load_The_Original_Signals = 1'b1;
                    state_nxt                 = LOAD;
                end
            end

            LOAD: begin
                // One settling cycle for the virtual master registers.
                state_nxt = ADDR;
            end

            ADDR: begin
                // Losing the grant here simply stalls; nothing is issued.
                if (M_AXI_awready && Token) begin
                    Burst_Out = 1'b1;
                    state_nxt = DATA;
                end
            end

            DATA: begin
                M_AXI_wvalid = S_AXI_wvalid;
                S_AXI_wready = M_AXI_wready;
                M_AXI_wlast  = beat_is_last;
                if (w_hs && beat_is_last) begin
                    state_nxt = RESP;
                end
            end

            RESP: begin
                M_AXI_bready = 1'b1;
                if (M_AXI_bvalid) begin
                    state_nxt = last_q ? SRESP : ADDR;
                end
            end

            SRESP: begin
                S_AXI_bvalid = 1'b1;
                S_AXI_bresp  = resp_acc;
                if (S_AXI_bready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the sub-burst length and last flag when its address is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            len_q  <= '0;
            last_q <= 1'b0;
        end else if (Burst_Out) begin
            len_q  <= Sub_Len;
            last_q <= Last_Trans;
        end
    end

    // Beat counter: restarts on each new sub-burst, advances on each W beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beat_cnt <= '0;
        end else if (Burst_Out) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Response merge: cleared at load, then keeps the worst sub-burst response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            resp_acc <= 2'b00;
        end else if (Load_The_Original_Signals) begin
            resp_acc <= 2'b00;
        end else if ((state == RESP) && M_AXI_bvalid) begin
            resp_acc <= resp_worst(resp_acc, M_AXI_bresp);
        end
    end

`ifdef AXI_WR_SPLIT_WLAST_CHECK_EN
    logic prot_err;

    // Sticky flag: upstream WLAST must mark exactly the last beat of the last sub-burst.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            prot_err <= 1'b0;
        end else if (w_hs && (S_AXI_wlast != (last_q && beat_is_last))) begin
            prot_err <= 1'b1;
        end
    end

    assign Protocol_Err = prot_err;
`else
    logic unused_wlast;

    assign unused_wlast = S_AXI_wlast;
    assign Protocol_Err = 1'b0;
`endif

endmodule
